// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//
// A round-robin arbiter accepts one operation at a time. The operands are
// held on the ALU for EXEC_CYCLES cycles, then the result is captured and
// returned on the granted requester's response channel. The block waits
// there until the requester takes the response.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   reqN_valid_i / reqN_ready_o   request handshake, N = 0, 1
//   reqN_src1_i, reqN_src2_i      operands
//   reqN_ctrl_i                   ALU op code, passed through unchanged
//   rspN_valid_o / rspN_ready_i   response handshake
//   rspN_result_o, rspN_zero_o    captured ALU result and zero flag
//   alu_src1_o, alu_src2_o        operands driven to the shared ALU
//   alu_ctrl_o                    op code driven to the shared ALU
//   alu_result_i, alu_zero_i      values returned by the shared ALU
//   busy_o                        high whenever an operation is in flight
//
// state | meaning
// IDLE  | waiting for a request; ready goes only to the arbitration winner
// EXEC  | operands held on the ALU while the cycle counter runs down
// RESP  | result held on the granted response channel until it is taken
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_src1_i,
  input  logic [31:0] req0_src2_i,
  input  logic [3:0]  req0_ctrl_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_src1_i,
  input  logic [31:0] req1_src2_i,
  input  logic [3:0]  req1_ctrl_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [31:0] rsp0_result_o,
  output logic        rsp0_zero_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp1_result_o,
  output logic        rsp1_zero_o,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  output logic        busy_o
);

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] src1_q, src2_q, result_q;
  logic [3:0]  ctrl_q, cnt_q;
  logic        zero_q;
  logic        grant_q;   // requester that owns the operation in flight
  logic        last_q;    // requester granted most recently
  logic        win;
  logic        req_hs;
  logic        rsp_hs;

  // Contention goes to the requester that was not granted last.
  always_comb begin
    win = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      win = ~last_q;
    end else if (req1_valid_i) begin
      win = 1'b1;
    end
  end

  // Ready is masked by rst_i so nothing is offered while reset is applied.
  assign req0_ready_o = (state == IDLE) && !rst_i && req0_valid_i && !win;
  assign req1_ready_o = (state == IDLE) && !rst_i && req1_valid_i && win;
  assign req_hs       = req0_ready_o || req1_ready_o;

  assign rsp0_valid_o = (state == RESP) && !grant_q;
  assign rsp1_valid_o = (state == RESP) && grant_q;
  assign rsp_hs       = (rsp0_valid_o && rsp0_ready_i) || (rsp1_valid_o && rsp1_ready_i);

  assign rsp0_result_o = result_q;
  assign rsp1_result_o = result_q;
  assign rsp0_zero_o   = zero_q;
  assign rsp1_zero_o   = zero_q;

  assign alu_src1_o = src1_q;
  assign alu_src2_o = src2_q;
  assign alu_ctrl_o = ctrl_q;
  assign busy_o     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_hs) state_nxt = EXEC;
      EXEC: if (cnt_q == 4'd1) state_nxt = RESP;
      RESP: if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      src1_q   <= '0;
      src2_q   <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
      grant_q  <= 1'b0;
      // Pretend requester 1 went last so requester 0 wins the first contention.
      last_q   <= 1'b1;
    end else begin
      state <= state_nxt;
      if (req_hs) begin
        src1_q  <= win ? req1_src1_i : req0_src1_i;
        src2_q  <= win ? req1_src2_i : req0_src2_i;
        ctrl_q  <= win ? req1_ctrl_i : req0_ctrl_i;
        grant_q <= win;
        last_q  <= win;
        cnt_q   <= EXEC_LOAD;
      end
      if (state == EXEC) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          result_q <= alu_result_i;
          zero_q   <= alu_zero_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (EXEC_CYCLES = 1 and 4), each with
// its own behavioural ALU, driven by directed and random operations and
// checked against expected grant order, latency and results.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic        rst       [2];
  logic [1:0]  rq_valid  [2];
  logic [31:0] rq_src1   [2][2];
  logic [31:0] rq_src2   [2][2];
  logic [3:0]  rq_ctrl   [2][2];
  logic [1:0]  rs_ready  [2];
  wire  [1:0]  rq_ready  [2];
  wire  [1:0]  rs_valid  [2];
  wire  [1:0]  rs_zero   [2];
  wire  [31:0] rs_result [2][2];
  wire  [31:0] alu_a     [2];
  wire  [31:0] alu_b     [2];
  wire  [3:0]  alu_op    [2];
  wire  [31:0] alu_y     [2];
  wire         alu_z     [2];
  wire         busy      [2];

  // Reference ALU: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 signed SLT, 12 NOR, else 0.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exec_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_arbiter #(.EXEC_CYCLES(g == 0 ? 1 : 4)) u_dut (
      .clk_i         (clk),
      .rst_i         (rst[g]),
      .req0_valid_i  (rq_valid[g][0]),
      .req0_ready_o  (rq_ready[g][0]),
      .req0_src1_i   (rq_src1[g][0]),
      .req0_src2_i   (rq_src2[g][0]),
      .req0_ctrl_i   (rq_ctrl[g][0]),
      .req1_valid_i  (rq_valid[g][1]),
      .req1_ready_o  (rq_ready[g][1]),
      .req1_src1_i   (rq_src1[g][1]),
      .req1_src2_i   (rq_src2[g][1]),
      .req1_ctrl_i   (rq_ctrl[g][1]),
      .rsp0_valid_o  (rs_valid[g][0]),
      .rsp0_ready_i  (rs_ready[g][0]),
      .rsp0_result_o (rs_result[g][0]),
      .rsp0_zero_o   (rs_zero[g][0]),
      .rsp1_valid_o  (rs_valid[g][1]),
      .rsp1_ready_i  (rs_ready[g][1]),
      .rsp1_result_o (rs_result[g][1]),
      .rsp1_zero_o   (rs_zero[g][1]),
      .alu_src1_o    (alu_a[g]),
      .alu_src2_o    (alu_b[g]),
      .alu_ctrl_o    (alu_op[g]),
      .alu_result_i  (alu_y[g]),
      .alu_zero_i    (alu_z[g]),
      .busy_o        (busy[g])
    );
    assign alu_y[g] = alu_ref(alu_op[g], alu_a[g], alu_b[g]);
    assign alu_z[g] = (alu_y[g] == 32'd0);
  end

  // Requester granted most recently, per instance (1 after reset so 0 wins).
  int exp_last [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reset one instance for one cycle while both requesters are valid.
  task automatic do_reset(input int k);
    @(negedge clk);
    rst[k] = 1'b1;
    rq_valid[k] = 2'b11;
    #1;
    chk("ready_during_reset", 32'(rq_ready[k]), 32'd0);
    @(negedge clk);
    rst[k] = 1'b0;
    rq_valid[k] = 2'b00;
    rs_ready[k] = 2'b00;
    #1;
    chk("reset_busy", 32'(busy[k]), 32'd0);
    chk("reset_rsp_valid", 32'(rs_valid[k]), 32'd0);
    chk("reset_alu_src1", alu_a[k], 32'd0);
    chk("reset_alu_src2", alu_b[k], 32'd0);
    chk("reset_alu_ctrl", 32'(alu_op[k]), 32'd0);
    exp_last[k] = 1;
  endtask

  // One complete operation: request, arbitration, latency, response hold
  // for 'hold' cycles with the other requester knocking, then release.
  task automatic run_op(input int k, input logic [1:0] vmask,
                        input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                        input int hold);
    int win, w, lat;
    logic [1:0]  em;
    logic [31:0] ea, eb, ey;
    logic [3:0]  ec;
    @(negedge clk);
    rq_ctrl[k][0] = c0; rq_src1[k][0] = a0; rq_src2[k][0] = b0;
    rq_ctrl[k][1] = c1; rq_src1[k][1] = a1; rq_src2[k][1] = b1;
    rq_valid[k] = vmask;
    win = (vmask == 2'b11) ? 1 - exp_last[k] : (vmask[1] ? 1 : 0);
    em  = (win == 1) ? 2'b10 : 2'b01;
    ea  = (win == 1) ? a1 : a0;
    eb  = (win == 1) ? b1 : b0;
    ec  = (win == 1) ? c1 : c0;
    ey  = alu_ref(ec, ea, eb);
    #1;
    w = 0;
    while (rq_ready[k] == 2'b00 && w < 20) begin
      @(negedge clk); #1; w++;
    end
    if (w >= 20) begin
      chk("ready_timeout", 32'd0, 32'd1);
      rq_valid[k] = 2'b00;
      return;
    end
    chk("grant", 32'(rq_ready[k]), 32'(em));
    exp_last[k] = win;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        rq_valid[k] = 2'b00;
        rq_src1[k][win] = ~ea;
        #1;
        chk("alu_src1_stable", alu_a[k], ea);
        chk("alu_ctrl", 32'(alu_op[k]), 32'(ec));
      end else begin
        #1;
      end
    end while (rs_valid[k] == 2'b00 && lat < 20);
    chk("latency", 32'(lat), 32'(exec_of(k) + 1));
    chk("rsp_valid", 32'(rs_valid[k]), 32'(em));
    chk("rsp_result", rs_result[k][win], ey);
    chk("rsp_result_other", rs_result[k][1-win], ey);
    chk("rsp_zero", 32'(rs_zero[k][win]), 32'(ey == 32'd0));
    chk("busy_resp", 32'(busy[k]), 32'd1);
    for (int i = 0; i < hold; i++) begin
      rq_valid[k][1-win] = 1'b1;
      #1;
      chk("bp_req_ready", 32'(rq_ready[k]), 32'd0);
      @(negedge clk); #1;
      chk("bp_rsp_valid", 32'(rs_valid[k]), 32'(em));
      chk("bp_result", rs_result[k][win], ey);
      chk("bp_busy", 32'(busy[k]), 32'd1);
    end
    rq_valid[k] = 2'b00;
    rs_ready[k][win] = 1'b1;
    @(negedge clk);
    rs_ready[k] = 2'b00;
    #1;
    chk("release_busy", 32'(busy[k]), 32'd0);
    chk("release_rsp_valid", 32'(rs_valid[k]), 32'd0);
  endtask

  function automatic logic [3:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 4'd0;
      1: return 4'd1;
      2: return 4'd2;
      3: return 4'd6;
      4: return 4'd7;
      5: return 4'd12;
      6: return 4'd3;
      default: return 4'd15;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          g_id[$], g_cyc[$], r_id[$];
    logic [31:0] r_val[$];
    logic        r_z[$];
    logic        seen;
    logic [31:0] ra0, rb0, ra1, rb1;

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0;
      rq_valid[k] = 2'b00;
      rs_ready[k] = 2'b00;
      exp_last[k] = 1;
      for (int j = 0; j < 2; j++) begin
        rq_src1[k][j] = '0; rq_src2[k][j] = '0; rq_ctrl[k][j] = '0;
      end
    end

    do_reset(0);
    do_reset(1);

    // Single ADD on requester 0.
    run_op(0, 2'b01, 4'd2, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 0);

    // Continuous contention with both response channels always ready.
    do_reset(0);
    @(negedge clk);
    rq_ctrl[0][0] = 4'd6; rq_src1[0][0] = 32'd3;    rq_src2[0][0] = 32'd3;
    rq_ctrl[0][1] = 4'd1; rq_src1[0][1] = 32'hF0;   rq_src2[0][1] = 32'h0F;
    rs_ready[0] = 2'b11;
    rq_valid[0] = 2'b11;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (rq_ready[0] != 2'b00) begin
        g_id.push_back(rq_ready[0][1] ? 1 : 0);
        g_cyc.push_back(i);
      end
      if (rs_valid[0] != 2'b00) begin
        r_id.push_back(rs_valid[0][1] ? 1 : 0);
        r_val.push_back(rs_valid[0][1] ? rs_result[0][1] : rs_result[0][0]);
        r_z.push_back(rs_valid[0][1] ? rs_zero[0][1] : rs_zero[0][0]);
      end
      @(negedge clk);
    end
    rq_valid[0] = 2'b00;
    rs_ready[0] = 2'b00;
    chk("cont_grant_count", 32'(g_id.size() >= 4), 32'd1);
    chk("cont_rsp_count", 32'(r_id.size() >= 4), 32'd1);
    if (g_id.size() >= 4 && r_id.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("cont_grant_order", 32'(g_id[i]), 32'(i % 2));
        chk("cont_rsp_id", 32'(r_id[i]), 32'(i % 2));
        chk("cont_rsp_result", r_val[i], (i % 2 == 1) ? 32'hFF : 32'h0);
        chk("cont_rsp_zero", 32'(r_z[i]), (i % 2 == 1) ? 32'd0 : 32'd1);
        if (i > 0) chk("cont_issue_interval", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
      end
    end
    do_reset(0);

    // Backpressure on requester 1's response for 5 cycles.
    run_op(0, 2'b10, 4'd0, 32'd0, 32'd0, 4'd1, 32'h1234_00F0, 32'h0000_0F0F, 5);

    // Longer execution window.
    run_op(1, 2'b01, 4'd0, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd0, 32'd0, 32'd0, 0);

    // Reset one cycle after a handshake from requester 1.
    @(negedge clk);
    rq_ctrl[1][1] = 4'd2; rq_src1[1][1] = 32'd100; rq_src2[1][1] = 32'd23;
    rq_valid[1] = 2'b10;
    #1;
    chk("rst_pre_grant", 32'(rq_ready[1]), 32'd2);
    do_reset(1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (rs_valid[1] != 2'b00 || busy[1]) seen = 1'b1;
    end
    chk("rst_no_response", 32'(seen), 32'd0);
    run_op(1, 2'b11, 4'd2, 32'd1, 32'd2, 4'd2, 32'd3, 32'd4, 0);

    // Random operations on both instances.
    for (int n = 0; n < 40; n++) begin
      int k;
      k   = int'($urandom_range(0, 1));
      ra0 = $urandom;
      rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
      ra1 = $urandom;
      rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
      run_op(k, 2'($urandom_range(1, 3)), pick_op(), ra0, rb0, pick_op(), ra1, rb1,
             int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: EXEC_CYCLES, default 1, number of cycles operands are held on the ALU before capture; legal range 1..15.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports req0_valid_i / req1_valid_i, input, 1 bit each: the requester has an operation pending.
REQ-005 The block SHALL have ports req0_ready_o / req1_ready_o, output, 1 bit each: the block accepts that requester's operation this cycle.
REQ-006 The block SHALL have ports reqN_src1_i and reqN_src2_i, input, 32 bits each, and reqN_ctrl_i, input, 4 bits: operands and ALU op code per requester.
REQ-007 The block SHALL have ports rspN_valid_o, output, 1 bit; rspN_ready_i, input, 1 bit; rspN_result_o, output, 32 bits; rspN_zero_o, output, 1 bit: the per-requester response channel.
REQ-008 The block SHALL have ports alu_src1_o and alu_src2_o, output, 32 bits each, and alu_ctrl_o, output, 4 bits: drive the shared combinational ALU.
REQ-009 The block SHALL have ports alu_result_i, input, 32 bits, and alu_zero_i, input, 1 bit: returned from the shared ALU.
REQ-010 The block SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-012 In IDLE, the block SHALL assert ready only to the arbitration winner; the winner is the sole valid requester, or, if both are valid, the requester not granted last (round-robin).
REQ-013 reqN_ready_o SHALL be combinational from state, valid inputs and priority pointer; it SHALL be 0 outside IDLE and 0 for the loser.
REQ-014 On a handshake (valid & ready) in IDLE, the block SHALL register src1, src2, ctrl and the grant id, update the priority pointer to the grant id, load the cycle counter with EXEC_CYCLES, and go to EXEC.
REQ-015 alu_src1_o, alu_src2_o and alu_ctrl_o SHALL always reflect the operand registers; the operand registers SHALL change only on an IDLE handshake.
REQ-016 In EXEC, the counter SHALL decrement each cycle; in the cycle it reads 1, the block SHALL capture alu_result_i and alu_zero_i into the result registers and go to RESP.
REQ-017 Latency SHALL be fixed: handshake in cycle T gives rspN_valid_o high from cycle T+EXEC_CYCLES+1.
REQ-018 In RESP, only the granted requester's rspN_valid_o SHALL be high, with rspN_result_o / rspN_zero_o equal to the captured values, held stable until rspN_ready_i is sampled high.
REQ-019 When rspN_valid_o & rspN_ready_i, the block SHALL return to IDLE and accept no new request in that same cycle; the earliest next handshake is the following cycle.
REQ-020 Both rspN_result_o outputs SHALL show the shared result register; only valid qualifies them.
REQ-021 A requester SHALL be allowed to drop valid without a handshake; no state change results.
REQ-022 ctrl codes SHALL pass through unmodified; unsupported codes produce whatever the ALU returns (0), and no error is flagged.
REQ-023 Minimum issue interval with EXEC_CYCLES=1 and rsp_ready tied high SHALL be 3 cycles.

Reset
REQ-024 With rst_i high at a rising edge, the block SHALL enter IDLE and clear the operand, ctrl, result, zero and counter registers to 0; it SHALL set the priority pointer so that requester 0 wins the first contention.
REQ-025 After reset, all rspN_valid_o SHALL be 0, busy_o SHALL be 0, and alu_* outputs SHALL be 0.
REQ-026 Reset in EXEC or RESP SHALL abandon the operation with no response issued; reqN_ready_o SHALL be 0 during the reset cycle.

Verification
REQ-027 Single op: req0 ADD 5+7, EXEC_CYCLES=1, rsp0_ready high -> rsp0_valid two cycles after the handshake, result 12, zero 0; rsp1_valid stays 0.
REQ-028 Contention: both valid continuously after reset, req0 SUB 3-3, req1 OR 0xF0|0x0F -> grants in order 0,1,0,1; rsp0 result 0 with zero 1; rsp1 result 0xFF.
REQ-029 Backpressure: rsp1_ready low for 5 cycles -> rsp1_valid, result and busy held; req0_ready stays 0; release -> IDLE the next cycle.
REQ-030 Latency parameter: EXEC_CYCLES=4, AND 0xFFFF0000&0x0F0F0F0F -> response 5 cycles after the handshake, result 0x0F0F0000.
REQ-031 Reset mid-EXEC: assert rst_i one cycle after a handshake -> no rsp valid, all outputs 0, and the next contention is won by req0.
REQ-032 Operand stability: change req0_src1_i after its handshake -> alu_src1_o and the captured result are unaffected.
